// File: rtl/dmem_mmio_bridge_if.sv
// Data-memory bus between the memory stage and the MMIO bridge.
// Ports: addr/wd/we driven by the stage; rd returned combinationally.
interface dmem_mmio_bridge_if;
   logic [31:0] addr;
   logic [31:0] wd;
   logic        we;
   logic [31:0] rd;

   modport master (
      output addr,
      output wd,
      output we,
      input  rd
   );

   modport slave (
      input  addr,
      input  wd,
      input  we,
      output rd
   );
endinterface

// File: rtl/dmem_mmio_bridge.sv
// Data RAM + MMIO (LED, switches, cycle counter, compare timer) bridge.
// Ports: clock, reset (async low), bus (slave), switches, leds, irq.
module dmem_mmio_bridge #(
   parameter int unsigned RAM_DEPTH = 64,
   parameter logic [31:0] MMIO_BASE = 32'h0000_0800,
   parameter int unsigned LED_WIDTH = 16,
   parameter int unsigned SW_WIDTH  = 16
) (
   input  logic                 clock,
   input  logic                 reset,
   dmem_mmio_bridge_if.slave    bus,
   input  logic [SW_WIDTH-1:0]  switches,
   output logic [LED_WIDTH-1:0] leds,
   output logic                 irq
);
   localparam int unsigned IDX_W     = $clog2(RAM_DEPTH);
   localparam logic [31:0] RAM_BYTES = 32'(4 * RAM_DEPTH);

   localparam logic [2:0] R_LED    = 3'd0;
   localparam logic [2:0] R_SW     = 3'd1;
   localparam logic [2:0] R_CYCLE  = 3'd2;
   localparam logic [2:0] R_CMP    = 3'd3;
   localparam logic [2:0] R_STATUS = 3'd4;
   localparam logic [2:0] R_TIMER  = 3'd5;

   logic             ram_hit;
   logic             mmio_hit;
   logic [IDX_W-1:0] ram_idx;
   logic [2:0]       reg_sel;
   logic             ram_we;
   logic             mmio_we;
   logic             match;
   logic [31:0]      rd_mmio;

   logic [31:0] mem_q [RAM_DEPTH];

   logic [LED_WIDTH-1:0] leds_q, leds_d;
   logic [SW_WIDTH-1:0]  sw_meta_q, sw_meta_d;
   logic [SW_WIDTH-1:0]  sw_sync_q, sw_sync_d;
   logic [31:0]          cycle_q, cycle_d;
   logic [31:0]          timer_q, timer_d;
   logic [31:0]          cmp_q, cmp_d;
   logic                 en_q, en_d;
   logic                 flag_q, flag_d;

   assign ram_hit  = bus.addr < RAM_BYTES;
   assign mmio_hit = bus.addr[31:5] == MMIO_BASE[31:5];
   assign ram_idx  = bus.addr[IDX_W+1:2];
   assign reg_sel  = bus.addr[4:2];
   // A write landing on an edge while reset is held is dropped.
   assign ram_we   = bus.we & ram_hit & reset;
   assign mmio_we  = bus.we & mmio_hit;
   assign match    = en_q && (timer_q == cmp_q);

   assign leds = leds_q;
   assign irq  = flag_q & en_q;

   always_comb begin
      rd_mmio = '0;
      unique case (reg_sel)
         R_LED:    rd_mmio = 32'(leds_q);
         R_SW:     rd_mmio = 32'(sw_sync_q);
         R_CYCLE:  rd_mmio = cycle_q;
         R_CMP:    rd_mmio = cmp_q;
         R_STATUS: rd_mmio = {30'd0, en_q, flag_q};
         R_TIMER:  rd_mmio = timer_q;
         default:  rd_mmio = '0;
      endcase
   end

   always_comb begin
      bus.rd = '0;
      unique case (1'b1)
         ram_hit:  bus.rd = mem_q[ram_idx];
         mmio_hit: bus.rd = rd_mmio;
         default:  bus.rd = '0;
      endcase
   end

   always_comb begin
      leds_d    = leds_q;
      cmp_d     = cmp_q;
      en_d      = en_q;
      flag_d    = flag_q;
      timer_d   = timer_q;
      sw_meta_d = switches;
      sw_sync_d = sw_meta_q;
      cycle_d   = cycle_q + 32'd1;
      if (en_q) begin
         timer_d = match ? '0 : timer_q + 32'd1;
      end
      // Software writes override the timer's own update.
      if (mmio_we) begin
         unique case (reg_sel)
            R_LED:    leds_d = bus.wd[LED_WIDTH-1:0];
            R_CMP:    cmp_d = bus.wd;
            R_STATUS: begin
               en_d = bus.wd[1];
               if (bus.wd[0]) flag_d = 1'b0;
            end
            R_TIMER:  timer_d = bus.wd;
            default:  ;
         endcase
      end
      // A match sets the flag even against a same-cycle clear.
      if (match) flag_d = 1'b1;
   end

   always_ff @(posedge clock) begin
      if (ram_we) mem_q[ram_idx] <= bus.wd;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         leds_q    <= '0;
         sw_meta_q <= '0;
         sw_sync_q <= '0;
         cycle_q   <= '0;
         timer_q   <= '0;
         cmp_q     <= '1;
         en_q      <= 1'b0;
         flag_q    <= 1'b0;
      end else begin
         leds_q    <= leds_d;
         sw_meta_q <= sw_meta_d;
         sw_sync_q <= sw_sync_d;
         cycle_q   <= cycle_d;
         timer_q   <= timer_d;
         cmp_q     <= cmp_d;
         en_q      <= en_d;
         flag_q    <= flag_d;
      end
   end
endmodule

// File: tb/tb_dmem_mmio_bridge.sv
// Scoreboard bench for dmem_mmio_bridge against a behavioural model.
// Driver pushes expected rd/leds/irq per cycle; monitor pops and checks.
module tb_dmem_mmio_bridge;
   localparam int RAM_DEPTH = 64;
   localparam logic [31:0] MB = 32'h0000_0800;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] switches = '0;
   logic [15:0] leds;
   logic        irq;

   dmem_mmio_bridge_if bus();

   dmem_mmio_bridge #(
      .RAM_DEPTH(RAM_DEPTH),
      .MMIO_BASE(MB),
      .LED_WIDTH(16),
      .SW_WIDTH(16)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus(bus),
      .switches(switches),
      .leds(leds),
      .irq(irq)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] rd;
      logic [15:0] leds;
      logic        irq;
   } exp_t;

   exp_t sb[$];
   int total = 0;
   int bad = 0;

   logic        rst_drv;
   logic [15:0] sw_drv;

   logic [31:0] m_ram [RAM_DEPTH];
   logic [15:0] m_leds, m_sw1, m_sw2;
   logic [31:0] m_cycle, m_timer, m_cmp;
   logic        m_en, m_flag;

   function automatic bit in_mmio(input logic [31:0] a);
      return (a >= MB) && (a < MB + 32'd32);
   endfunction

   function automatic void m_reset();
      m_leds = '0; m_sw1 = '0; m_sw2 = '0;
      m_cycle = '0; m_timer = '0; m_cmp = 32'hFFFF_FFFF;
      m_en = 1'b0; m_flag = 1'b0;
   endfunction

   function automatic logic [31:0] m_read(input logic [31:0] a);
      logic [31:0] off;
      if (a < 32'(4 * RAM_DEPTH)) return m_ram[a[7:2]];
      if (!in_mmio(a)) return '0;
      off = (a - MB) >> 2;
      case (off)
         0: return {16'd0, m_leds};
         1: return {16'd0, m_sw2};
         2: return m_cycle;
         3: return m_cmp;
         4: return {30'd0, m_en, m_flag};
         5: return m_timer;
         default: return '0;
      endcase
   endfunction

   function automatic void m_step(input logic [31:0] a, input logic [31:0] d,
                                  input logic w, input logic [15:0] sw);
      bit hit;
      logic [31:0] nt;
      logic [31:0] off;
      hit = m_en && (m_timer == m_cmp);
      nt = m_timer;
      if (m_en) nt = hit ? 32'd0 : m_timer + 32'd1;
      if (w && a < 32'(4 * RAM_DEPTH)) m_ram[a[7:2]] = d;
      if (w && in_mmio(a)) begin
         off = (a - MB) >> 2;
         case (off)
            0: m_leds = d[15:0];
            3: m_cmp = d;
            4: begin
               m_en = d[1];
               if (d[0]) m_flag = 1'b0;
            end
            5: nt = d;
            default: ;
         endcase
      end
      if (hit) m_flag = 1'b1;
      m_timer = nt;
      m_cycle = m_cycle + 32'd1;
      m_sw2 = m_sw1;
      m_sw1 = sw;
   endfunction

   task automatic cyc(input logic [31:0] a, input logic [31:0] d, input logic w);
      exp_t e;
      @(negedge clock);
      reset = rst_drv;
      switches = sw_drv;
      bus.addr = a;
      bus.wd = d;
      bus.we = w;
      if (!rst_drv) m_reset();
      e.addr = a;
      e.rd = m_read(a);
      e.leds = m_leds;
      e.irq = m_flag & m_en;
      sb.push_back(e);
      if (rst_drv) m_step(a, d, w, sw_drv);
   endtask

   task automatic wait_match();
      int n;
      n = 0;
      while (!(m_en && m_timer == m_cmp) && n < 40) begin
         cyc(MB + 32'h10, 0, 1'b0);
         n++;
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clock);
         #2;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            total++;
            if (bus.rd !== e.rd) begin
               bad++;
               $display("FAIL rd addr=%h got=%h exp=%h", e.addr, bus.rd, e.rd);
            end
            total++;
            if (leds !== e.leds) begin
               bad++;
               $display("FAIL leds addr=%h got=%h exp=%h", e.addr, leds, e.leds);
            end
            total++;
            if (irq !== e.irq) begin
               bad++;
               $display("FAIL irq addr=%h got=%b exp=%b", e.addr, irq, e.irq);
            end
         end
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stim
      logic [31:0] a, d;
      logic w;
      rst_drv = 1'b0;
      sw_drv = '0;
      m_reset();
      for (int i = 0; i < RAM_DEPTH; i++) m_ram[i] = '0;
      bus.addr = '0;
      bus.wd = '0;
      bus.we = 1'b0;

      for (int i = 0; i < 8; i++) cyc(MB + 32'(i * 4), 0, 1'b0);
      rst_drv = 1'b1;

      for (int i = 0; i < RAM_DEPTH; i++) cyc(32'(i * 4), $urandom, 1'b1);

      cyc(32'h10, 32'hDEAD_BEEF, 1'b1);
      cyc(32'h10, 0, 1'b0);
      cyc(32'h13, 0, 1'b0);
      cyc(32'h14, 0, 1'b0);
      cyc(32'h14, 32'h5555_AAAA, 1'b1);
      cyc(32'h14, 0, 1'b0);

      cyc(32'h100, 32'h1234_5678, 1'b1);
      cyc(32'h100, 0, 1'b0);
      for (int i = 0; i < RAM_DEPTH; i++) cyc(32'(i * 4), 0, 1'b0);

      cyc(MB, 32'hFFFF_ABCD, 1'b1);
      cyc(MB, 0, 1'b0);
      cyc(MB + 32'h18, 32'hFFFF_FFFF, 1'b1);
      cyc(MB + 32'h18, 0, 1'b0);
      cyc(MB + 32'h1C, 0, 1'b0);
      cyc(MB + 32'h08, 32'h0, 1'b1);
      cyc(MB + 32'h08, 0, 1'b0);
      cyc(MB + 32'h04, 32'hFFFF, 1'b1);

      sw_drv = 16'h00F0;
      repeat (4) cyc(MB + 32'h04, 0, 1'b0);

      cyc(MB + 32'h0C, 32'd5, 1'b1);
      cyc(MB + 32'h10, 32'h2, 1'b1);
      repeat (14) cyc(MB + 32'h14, 0, 1'b0);
      cyc(MB + 32'h10, 32'h3, 1'b1);
      repeat (3) cyc(MB + 32'h10, 0, 1'b0);

      wait_match();
      cyc(MB + 32'h10, 32'h3, 1'b1);
      cyc(MB + 32'h10, 0, 1'b0);
      wait_match();
      cyc(MB + 32'h14, 32'd100, 1'b1);
      cyc(MB + 32'h14, 0, 1'b0);
      cyc(MB + 32'h10, 0, 1'b0);
      cyc(MB + 32'h14, 32'd0, 1'b1);
      wait_match();
      cyc(MB + 32'h10, 32'h0, 1'b1);
      cyc(MB + 32'h10, 0, 1'b0);
      cyc(MB + 32'h14, 0, 1'b0);

      for (int i = 0; i < 1500; i++) begin
         case ($urandom_range(0, 3))
            0, 1: a = 32'($urandom_range(0, 255));
            2: a = MB + 32'($urandom_range(0, 31));
            default: a = $urandom_range(0, 1) ?
                         32'h100 + 32'($urandom_range(0, 1791)) : $urandom;
         endcase
         d = $urandom_range(0, 1) ? 32'($urandom_range(0, 15)) : $urandom;
         w = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 15) == 0) sw_drv = 16'($urandom);
         cyc(a, d, w);
      end

      cyc(32'h10, 32'hDEAD_BEEF, 1'b1);
      cyc(MB + 32'h0C, 32'hFFFF_0000, 1'b1);
      cyc(MB + 32'h14, 32'd0, 1'b1);
      cyc(MB + 32'h10, 32'h3, 1'b1);
      cyc(MB, 32'h0000_5A5A, 1'b1);
      for (int i = 0; i < 1000; i++) cyc(MB + 32'h08, 0, 1'b0);
      cyc(MB + 32'h14, 0, 1'b0);

      rst_drv = 1'b0;
      cyc(MB + 32'h08, 0, 1'b0);
      cyc(MB + 32'h14, 0, 1'b0);
      cyc(MB, 0, 1'b0);
      cyc(MB + 32'h0C, 0, 1'b0);
      cyc(MB + 32'h10, 0, 1'b0);
      cyc(32'h10, 0, 1'b0);
      cyc(32'h20, 32'hBAD0_BAD0, 1'b1);
      cyc(32'h20, 0, 1'b0);
      rst_drv = 1'b1;
      repeat (4) cyc(MB + 32'h08, 0, 1'b0);
      cyc(32'h20, 0, 1'b0);
      cyc(32'h10, 0, 1'b0);

      repeat (3) @(negedge clock);
      #3;
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL drain left=%0d required=0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/dmem_mmio_bridge.md
Name: dmem_mmio_bridge

Overview:
- Sits directly downstream of the datapath memory stage. It consumes the memory-stage address (alu_out), write data (dmem_wd) and write enable (dmem_we).
- It returns read data (dmem_rd), which the writeback register captures on the same clock edge.
- It decodes the address into a word-addressed data RAM and a small memory-mapped I/O region: LEDs, switch input, cycle counter, and a compare timer with interrupt flag.

Parameters:
- RAM_DEPTH, 64, number of 32-bit RAM words; must be a power of 2, max 512.
- MMIO_BASE, 32'h0000_0800, byte address of the first MMIO register; RAM occupies 0 .. 4*RAM_DEPTH-1.
- LED_WIDTH, 16, width of the LED output register.
- SW_WIDTH, 16, width of the switch input.

Ports:
- clock  input  1  single system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- addr  input  32  byte address from memory stage (alu_out).
- wd  input  32  write data from memory stage (dmem_wd).
- we  input  1  write enable from memory stage (dmem_we).
- rd  output  32  read data to writeback; combinational from addr and current state.
- switches  input  SW_WIDTH  raw asynchronous board switches.
- leds  output  LED_WIDTH  LED register contents.
- irq  output  1  timer interrupt = match_flag & timer_en.

Behaviour:
- Reset (reset=0, asynchronous) clears the following; RAM contents are not reset:
  - leds = 0, switch synchronizer flops = 0, cycle = 0
  - timer = 0, timer_cmp = 32'hFFFF_FFFF, timer_en = 0, match_flag = 0, irq = 0
- Address decode uses addr[1:0] ignored (word aligned), so no misalignment fault.
  - RAM hit: addr < 4*RAM_DEPTH; index = addr[log2(RAM_DEPTH)+1:2].
  - MMIO hit: addr[31:5] == MMIO_BASE[31:5]; register = addr[4:2].
  - Anything else: unmapped; reads return 0, writes ignored.
- Reads are zero-latency: rd is valid in the same cycle addr is presented. RAM is an asynchronous-read register array.
- Writes take effect at the rising edge where we=1.
- Read and write to the same location in the same cycle: rd shows the old value.
- MMIO map (offset from MMIO_BASE):
  - 0x00 LED: rw; low LED_WIDTH bits stored; read zero-extends.
  - 0x04 SW: ro; 2-flop synchronized switches, zero-extended; 2-cycle latency from pin to rd.
  - 0x08 CYCLE: ro; free-running, +1 every cycle, wraps FFFF_FFFF -> 0.
  - 0x0C TIMER_CMP: rw.
  - 0x10 STATUS: bit0 match_flag (read; write 1 clears; write 0 no effect); bit1 timer_en (rw); other bits read 0.
  - 0x14 TIMER: rw; when timer_en=1, increments each cycle.
    - When timer == timer_cmp and timer_en=1: next value is 0 and match_flag is set.
  - 0x18, 0x1C: unmapped; read 0.
- Simultaneous events, same cycle:
  - Timer match and W1C of match_flag: set wins; flag stays 1.
  - Software write to TIMER and a match or increment: software write wins. The flag is still set if the match condition held this cycle.
  - Writing STATUS with bit1=0 and a match: flag is set; en clears.
- Writes to CYCLE and SW are ignored.
- irq is combinational from registered match_flag and timer_en; no extra latency.
- Reset asserted mid-operation aborts any pending write. State returns to reset values immediately and asynchronously; reset deassertion takes effect at the next edge.

Test Plan:
- RAM write/read: write 32'hDEADBEEF to addr 0x10 -> the next cycle a read of addr 0x10 returns DEADBEEF; a read of addr 0x13 returns DEADBEEF; a read of addr 0x14 is unaffected.
- Unmapped access and LED masking:
  - Write 0x1234_5678 to 4*RAM_DEPTH (0x100) -> a read returns 0; RAM words 0..63 unchanged.
  - Write 0xFFFF_ABCD to LED -> leds = 16'hABCD; LED reads 0x0000_ABCD.
- Switch sync: switches go 0 -> 16'h00F0 at cycle N -> SW reads 0 at N and N+1, and 0x00F0 from N+2.
- Timer match:
  - Setup: TIMER_CMP = 5, STATUS = 0x2.
  - Timer counts 0..5, then 0.
  - match_flag and irq go 1 on the edge where timer wraps 5 -> 0, and stay 1.
  - Writing STATUS = 0x3 clears the flag; irq = 0 one edge later.
- Collision: W1C in the same cycle as the next match -> flag remains 1. Write TIMER = 100 during a match cycle -> timer reads 100 next cycle and flag = 1.
- Reset mid-run:
  - Setup: after 1000 cycles with the timer enabled, pull reset low between edges.
  - Required: cycle, timer, leds and irq read 0 immediately; timer_cmp reads FFFF_FFFF.
  - RAM word at 0x10 still holds DEADBEEF.
  - Once reset is released, cycle increments from 0.
